// File: rtl/clock_pkg.sv
// Shared encodings and limits for the time-of-day controller.
package clock_pkg;

  localparam logic [1:0] MODE_RUN     = 2'd0;
  localparam logic [1:0] MODE_SET_HR  = 2'd1;
  localparam logic [1:0] MODE_SET_MIN = 2'd2;
  localparam logic [1:0] MODE_SET_SEC = 2'd3;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int BLANK_HR  = 3;
  localparam int BLANK_MIN = 2;
  localparam int BLANK_SEC = 1;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down counter; carry is combinational so fields cascade on one edge.
module mod_counter #(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] count,
  output logic       carry
);

  logic up;
  logic down;

  // Simultaneous inc and dec cancel out.
  assign up    = inc & ~dec;
  assign down  = dec & ~inc;
  assign carry = up & (count == 8'(MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 8'd0;
    end else if (up) begin
      count <= (count == 8'(MAX)) ? 8'd0 : count + 8'd1;
    end else if (down) begin
      count <= (count == 8'd0) ? 8'(MAX) : count - 8'd1;
    end
  end

endmodule

// File: rtl/clock_time_controller.sv
// Time-of-day keeper with mode/inc/dec keys and a blinking field under adjustment.
// mode | meaning: 0 RUN (time advances) | 1 SET_HR | 2 SET_MIN | 3 SET_SEC (prescaler held at 0)
module clock_time_controller
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [7:0] num2,
  output logic [7:0] num1,
  output logic [7:0] num0,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       tick_1hz
);

  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [2:0]    key_s, key_q, pulse;
  logic          mode_p, inc_p, dec_p, running, wrap, blink_rst;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          phase, phase_next;
  logic [1:0]    mode_next;
  logic [3:0]    blank_next;
  logic          sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic          sec_carry, min_carry;

  // Extra input stage gives one cycle of key-to-output latency; ones at reset hide held keys.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s <= 3'b111;
      key_q <= 3'b111;
    end else begin
      key_s <= {key_mode, key_inc, key_dec};
      key_q <= key_s;
    end
  end

  assign pulse   = key_s & ~key_q;
  assign mode_p  = pulse[2];
  assign inc_p   = pulse[1] & ~mode_p;
  assign dec_p   = pulse[0] & ~mode_p;
  assign running = (mode == MODE_RUN);
  assign wrap    = running && (presc == PW'(CLK_HZ - 1));

  assign sec_inc = wrap | ((mode == MODE_SET_SEC) & inc_p);
  assign sec_dec = (mode == MODE_SET_SEC) & dec_p;
  assign min_inc = (running & sec_carry) | ((mode == MODE_SET_MIN) & inc_p);
  assign min_dec = (mode == MODE_SET_MIN) & dec_p;
  assign hr_inc  = (running & min_carry) | ((mode == MODE_SET_HR) & inc_p);
  assign hr_dec  = (mode == MODE_SET_HR) & dec_p;

  mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .dec(sec_dec), .count(num0), .carry(sec_carry)
  );
  mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .dec(min_dec), .count(num1), .carry(min_carry)
  );
  mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .dec(hr_dec), .count(num2), .carry()
  );

  assign blink_rst = mode_p | (~running & (pulse[1] | pulse[0]));
  assign mode_next = mode + {1'b0, mode_p};

  always_comb begin
    blink_cnt_next = blink_cnt + BW'(1);
    phase_next     = phase;
    if (blink_rst) begin
      blink_cnt_next = '0;
      phase_next     = 1'b1;
    end else if (blink_cnt == BW'(HALF - 1)) begin
      blink_cnt_next = '0;
      phase_next     = ~phase;
    end
    blank_next = 4'b1111;
    case (mode_next)
      MODE_SET_HR:  blank_next[BLANK_HR]  = phase_next;
      MODE_SET_MIN: blank_next[BLANK_MIN] = phase_next;
      MODE_SET_SEC: blank_next[BLANK_SEC] = phase_next;
      default:      blank_next = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      tick_1hz  <= 1'b0;
      mode      <= MODE_RUN;
      blink_cnt <= '0;
      phase     <= 1'b1;
      blank     <= 4'b1111;
    end else begin
      presc     <= (!running || wrap) ? '0 : presc + PW'(1);
      tick_1hz  <= wrap;
      mode      <= mode_next;
      blink_cnt <= blink_cnt_next;
      phase     <= phase_next;
      blank     <= blank_next;
    end
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// Directed plus random stimulus against a seconds-of-day reference model.
module tb_clock_time_controller;

  localparam int CLK_HZ = 8;
  localparam int BLINK_HZ = 2;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [7:0] num2, num1, num0;
  logic [3:0] blank;
  logic [1:0] mode;
  logic tick_1hz;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_t, m_mode, m_presc, m_age;
  bit m_tick;
  bit [2:0] h1, h2;

  always #5 clk = ~clk;

  clock_time_controller #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) dut (
    .clk(clk), .reset(reset), .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .num2(num2), .num1(num1), .num0(num0), .blank(blank), .mode(mode), .tick_1hz(tick_1hz)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_mode = 0; m_presc = 0; m_age = 0; m_tick = 0;
    h1 = 3'b111; h2 = 3'b111;
  endtask

  function automatic logic [3:0] exp_blank();
    logic [3:0] b;
    bit vis;
    b = 4'b1111;
    vis = ((m_age / HALF) % 2) == 0;
    if (m_mode == 1) b[3] = vis;
    if (m_mode == 2) b[2] = vis;
    if (m_mode == 3) b[1] = vis;
    return b;
  endfunction

  task automatic model_edge();
    bit [2:0] cur;
    bit mp, ip, dp, anyid;
    int h, m, s, d;
    cur = {key_mode, key_inc, key_dec};
    if (reset) begin
      model_reset();
      return;
    end
    mp = h1[2] & ~h2[2];
    ip = h1[1] & ~h2[1] & ~mp;
    dp = h1[0] & ~h2[0] & ~mp;
    anyid = (h1[1] & ~h2[1]) | (h1[0] & ~h2[0]);
    h2 = h1; h1 = cur;
    m_tick = 0;
    if (m_mode == 0) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0; m_tick = 1; m_t = (m_t + 1) % 86400;
      end else m_presc++;
    end else begin
      m_presc = 0;
      if (ip ^ dp) begin
        d = ip ? 1 : -1;
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        if (m_mode == 1) h = (h + d + 24) % 24;
        if (m_mode == 2) m = (m + d + 60) % 60;
        if (m_mode == 3) s = (s + d + 60) % 60;
        m_t = h * 3600 + m * 60 + s;
      end
    end
    if (mp || (m_mode != 0 && anyid)) m_age = 0; else m_age++;
    m_mode = (m_mode + int'(mp)) % 4;
  endtask

  task automatic check_all();
    chk("num2", num2, 8'(m_t / 3600));
    chk("num1", num1, 8'((m_t / 60) % 60));
    chk("num0", num0, 8'(m_t % 60));
    chk("mode", {6'b0, mode}, 8'(m_mode));
    chk("blank", {4'b0, blank}, {4'b0, exp_blank()});
    chk("tick", {7'b0, tick_1hz}, {7'b0, m_tick});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_key(input int k, input logic v);
    if (k == 2) key_mode = v;
    else if (k == 1) key_inc = v;
    else key_dec = v;
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1); cycle(); cycle();
    set_key(k, 1'b0); cycle(); cycle();
  endtask

  task automatic goto_mode(input int tgt);
    for (int i = 0; i < 4; i++) if (m_mode != tgt) press(2);
  endtask

  initial begin
    model_reset();
    cycle(); cycle();
    chk("rst_num0", num0, 8'd0);
    chk("rst_blank", {4'b0, blank}, 8'h0f);
    chk("rst_mode", {6'b0, mode}, 8'd0);
    reset = 1'b0;

    // 1: free run
    repeat (7) cycle();
    chk("pre_tick", {7'b0, tick_1hz}, 8'd0);
    cycle();
    chk("tick1", {7'b0, tick_1hz}, 8'd1);
    chk("num0_first", num0, 8'd1);
    repeat (8) cycle();
    chk("num0_second", num0, 8'd2);

    // 2: set 23:59:59 then roll over
    goto_mode(1); press(0);
    press(2); press(0);
    press(2);
    for (int i = 0; i < 60 && (m_t % 60) != 59; i++) press(0);
    chk("set_hr", num2, 8'd23);
    chk("set_min", num1, 8'd59);
    chk("set_sec", num0, 8'd59);
    key_mode = 1'b1; cycle(); cycle();
    key_mode = 1'b0;
    chk("back_run", {6'b0, mode}, 8'd0);
    repeat (7) cycle();
    chk("no_early_tick", {7'b0, tick_1hz}, 8'd0);
    cycle();
    chk("roll_hr", num2, 8'd0);
    chk("roll_min", num1, 8'd0);
    chk("roll_sec", num0, 8'd0);
    chk("roll_tick", {7'b0, tick_1hz}, 8'd1);
    cycle();
    chk("tick_single", {7'b0, tick_1hz}, 8'd0);

    // 3: mode cycling with blink
    key_mode = 1'b1; cycle(); cycle();
    chk("blink_vis", {4'b0, blank}, 8'h0f);
    key_mode = 1'b0; cycle(); cycle();
    chk("blink_hid", {4'b0, blank}, 8'h07);
    repeat (6) cycle();
    press(2); repeat (6) cycle();
    press(2); repeat (6) cycle();
    press(2); repeat (6) cycle();

    // 4: minute and hour wrap via dec/inc
    goto_mode(2);
    for (int i = 0; i < 60 && ((m_t / 60) % 60) != 0; i++) press(1);
    press(0);
    chk("min_dec_wrap", num1, 8'd59);
    chk("hr_untouched", num2, 8'(m_t / 3600));
    press(1);
    chk("min_inc_wrap", num1, 8'd0);
    goto_mode(1);
    for (int i = 0; i < 24 && (m_t / 3600) != 0; i++) press(1);
    press(0);
    chk("hr_dec_wrap", num2, 8'd23);

    // 5: simultaneous keys, held key, key held through reset
    key_inc = 1'b1; key_dec = 1'b1; cycle(); cycle();
    key_inc = 1'b0; key_dec = 1'b0; cycle(); cycle();
    chk("both_keys", num2, 8'd23);
    key_inc = 1'b1; repeat (20) cycle();
    key_inc = 1'b0; cycle(); cycle();
    chk("held_inc", num2, 8'd0);
    key_mode = 1'b1; reset = 1'b1; cycle();
    reset = 1'b0; repeat (5) cycle();
    chk("held_mode_rst", {6'b0, mode}, 8'd0);
    key_mode = 1'b0; cycle();

    // 6: async reset mid-cycle in SET_SEC
    goto_mode(3);
    for (int i = 0; i < 60 && (m_t % 60) != 37; i++) press(1);
    chk("sec37", num0, 8'd37);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_num2", num2, 8'd0);
    chk("async_num1", num1, 8'd0);
    chk("async_num0", num0, 8'd0);
    chk("async_mode", {6'b0, mode}, 8'd0);
    chk("async_blank", {4'b0, blank}, 8'h0f);
    cycle();
    reset = 1'b0;

    // random stimulus
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) key_mode = ~key_mode;
      if ($urandom_range(0, 4) == 0) key_inc = ~key_inc;
      if ($urandom_range(0, 4) == 0) key_dec = ~key_dec;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
Time-of-day source that drives the seven-segment display path's num2/num1/num0, blank and mode inputs. It keeps hours:minutes:seconds from a prescaled system clock. A debounced mode key cycles through run and three set states. Inc/dec keys adjust the selected field, and that field blinks via its blank bit.

Parameters:
CLK_HZ, 50_000_000, system clock frequency; prescaler counts 0..CLK_HZ-1 per second.
BLINK_HZ, 2, blink rate of the field being set; half-period = CLK_HZ/(2*BLINK_HZ) cycles, must be an integer >= 1.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-high reset.
key_mode  input  1  debounced, synchronised level; rising edge = advance mode.
key_inc  input  1  debounced, synchronised level; rising edge = increment the selected field.
key_dec  input  1  debounced, synchronised level; rising edge = decrement the selected field.
num2  output  8  hours, binary 0..23, bits [7:5] always 0.
num1  output  8  minutes, binary 0..59, bits [7:6] always 0.
num0  output  8  seconds, binary 0..59, bits [7:6] always 0.
blank  output  4  per-field display enable, 1 = visible. [3]=hours, [2]=minutes, [1]=seconds, [0] constant 1.
mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC.
tick_1hz  output  1  one-cycle pulse on each seconds advance in RUN.

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values: num2=num1=num0=0, mode=RUN, blank=4'b1111, tick_1hz=0, prescaler=0, blink phase=visible.
- Reset also sets the key edge-history registers to 1, so a key held through reset produces no edge.
- All outputs are registered.
- Edge detect: pulse = key & ~key_q. A rising edge sampled at edge n is reflected on the outputs after edge n+1 (1-cycle latency).
- A held key gives exactly one action; there is no auto-repeat.
- Mode FSM: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN, one step per key_mode edge.
- RUN state:
  - The prescaler increments every cycle.
  - When the prescaler is at CLK_HZ-1 it wraps to 0, tick_1hz=1 for that cycle, and seconds advance on the same edge.
  - Carries: seconds 59 -> 0 increments minutes; minutes 59 -> 0 increments hours; hours 23 -> 0.
  - inc/dec edges are ignored.
- SET states:
  - The prescaler is held at 0, so timekeeping pauses.
  - Selected field: inc wraps max -> 0; dec wraps 0 -> max (59 for minutes/seconds, 23 for hours).
  - Adjustments never carry into other fields.
- Transition SET_SEC -> RUN: prescaler is already 0, so the first tick arrives CLK_HZ cycles after entry.
- Blink:
  - In SET_x, the selected field's blank bit toggles every half-period; the other bits stay 1.
  - In RUN, blank=4'b1111.
  - The blink counter and phase reset to visible on every mode change and on every accepted inc/dec edge.
- Simultaneous events:
  - inc and dec edges in the same cycle: no change to any field, but the blink phase still resets.
  - key_mode edge together with inc/dec: the mode change applies and inc/dec is ignored.
  - key_mode edge in the same cycle as a RUN prescaler wrap: the tick and seconds advance apply first, then the mode becomes SET_HR.
- Reset mid-operation forces all outputs immediately, without waiting for a clock edge.

Decomposition:
- Shared package clock_pkg:
  - mode encodings MODE_RUN/MODE_SET_HR/MODE_SET_MIN/MODE_SET_SEC;
  - SEC_MAX=59, MIN_MAX=59, HR_MAX=23;
  - blank bit indices BLANK_HR=3, BLANK_MIN=2, BLANK_SEC=1.
- One sub-module, mod_counter, instantiated three times (hours, minutes, seconds):
  - parameter MAX;
  - inputs clk, reset, inc, dec;
  - outputs count[7:0], carry (pulse on MAX -> 0 via inc).
- Top-level glue: FSM, prescaler, blink logic, edge detectors.

Test Plan (CLK_HZ=8, BLINK_HZ=2, so the blink half-period is 2 cycles):
1. Reset, then idle in RUN -> tick_1hz pulses every 8 cycles; num0 reads 1 after the first tick and 2 after the second; blank=1111, mode=0.
2. Set 23:59:59 via the keys, return to RUN -> after 8 cycles num2/num1/num0 = 0/0/0 with a single tick_1hz pulse.
3. Four key_mode edges -> mode goes 1,2,3,0. In mode 1, blank toggles 1111/0111 every 2 cycles; in mode 3, 1111/1101; in mode 0, constant 1111.
4. SET_MIN with minutes=0: dec edge -> 59, then inc -> 0; hours unchanged throughout. SET_HR: dec from 0 -> 23.
5. inc and dec rise on the same cycle -> field unchanged. inc held high 20 cycles -> field +1 only. key_mode held through reset release -> mode stays RUN.
6. In SET_SEC with seconds=37, assert reset asynchronously mid-cycle -> outputs go to 0/0/0, mode=0, blank=1111 before the next clk edge.
